xif_mem_responder: RTL and testbench
====================================

XIF_MEM_RESPONDER -- requirements
Module: xif_mem_responder

Interface
REQ-001 Parameter: ZeroWaitAccept, default 1'b0. When 1, the OBI request SHALL be issued combinationally in the accept cycle; otherwise it SHALL be issued one cycle after accept.
REQ-002 Port: clk_i, input, 1, the single clock.
REQ-003 Port: rst_ni, input, 1, reset. It is asynchronous and active-low.
REQ-004 Port: x_mem_valid_i, input, 1, coprocessor memory request valid.
REQ-005 Port: x_mem_ready_o, output, 1, request accepted by the responder.
REQ-006 Port: x_mem_req_i, input, x_mem_req_t, the request (id, addr, mode, we, size, be, attr, wdata, last, spec).
REQ-007 Port: x_mem_resp_o, output, x_mem_resp_t, the response; valid whenever x_mem_valid_i && x_mem_ready_o.
REQ-008 Port: x_mem_result_valid_o, output, 1, result valid. There is no ready; the result SHALL be consumed on assertion.
REQ-009 Port: x_mem_result_o, output, x_mem_result_t, fields id, rdata, err, dbg.
REQ-010 Ports: data_req_o (output, 1), data_gnt_i (input, 1), data_addr_o (output, 32), data_we_o (output, 1), data_be_o (output, 4), data_wdata_o (output, 32). Together they form the OBI A-channel to the data bus.
REQ-011 Ports: data_rvalid_i (input, 1), data_rdata_i (input, 32), data_err_i (input, 1). Together they form the OBI R-channel.

Function
REQ-012 The FSM SHALL have the states IDLE, REQ, WAIT, RESULT. At most one transaction SHALL be outstanding at any time.
REQ-013 x_mem_ready_o SHALL be 1 only in IDLE.
REQ-014 The alignment check SHALL apply only to accepted requests, as follows:
- size 0: always aligned.
- size 1: misaligned if addr[0]=1.
- size 2: misaligned if addr[1:0]!=0.
- size >=3: always misaligned.
REQ-015 On a misaligned accept, the responder SHALL behave as follows:
- x_mem_resp_o.exc=1 in the same cycle.
- exccode=EXC_LD_ADDR_MISALIGNED (4) if we=0; exccode=EXC_ST_ADDR_MISALIGNED (6) if we=1.
- No bus access and no result are generated; the FSM stays in IDLE.
REQ-016 On an aligned accept, the responder SHALL set resp.exc=0 and exccode=0, latch id, addr, we, be and wdata, and go to REQ. With ZeroWaitAccept=1, data_req_o SHALL also assert in the accept cycle, and the FSM goes directly to WAIT if data_gnt_i=1.
REQ-017 In REQ, data_req_o=1 SHALL be held and the latched A-channel fields SHALL be stable until data_gnt_i=1; the FSM then goes to WAIT.
REQ-018 In WAIT, when data_rvalid_i=1 the responder SHALL register rdata (forced to 0 for stores) and err=data_err_i, then go to RESULT.
REQ-019 In RESULT, x_mem_result_valid_o SHALL be 1 for exactly one cycle, with result.id equal to the latched id; the FSM then goes to IDLE.
REQ-020 x_mem_resp_o.dbg and x_mem_result_o.dbg SHALL always be 0.
REQ-021 data_rvalid_i in IDLE, REQ or RESULT SHALL be ignored.
REQ-022 With ZeroWaitAccept=0, best-case latency from accept to result_valid SHALL be 3 cycles, with gnt and rvalid each arriving at their earliest cycle.
REQ-023 A bus error SHALL NOT raise resp.exc; it SHALL be reported only via result.err.

Reset
REQ-024 While rst_ni=0, the following SHALL hold:
- state=IDLE.
- data_req_o=0, x_mem_result_valid_o=0, x_mem_ready_o=1.
- All latched fields and x_mem_result_o are 0.
REQ-025 A reset during REQ or WAIT SHALL abandon the transaction; no result SHALL be produced afterwards.

Structure
REQ-026 The constants EXC_LD_ADDR_MISALIGNED=6'd4 and EXC_ST_ADDR_MISALIGNED=6'd6 SHALL be placed in fpu_ss_pkg.
REQ-027 The x_mem_* struct types SHALL be reused from fpu_ss_pkg.
REQ-028 The FSM state enum SHALL be local to the module.
REQ-029 The design SHALL have no sub-module; the alignment check is inline combinational logic.

Verification
REQ-030 Word load, addr 0x1000, id 3, gnt same cycle, rvalid next cycle with rdata 0xDEADBEEF -> resp.exc=0; one-cycle result with id 3, rdata 0xDEADBEEF, err=0.
REQ-031 Halfword store, addr 0x2001 -> same-cycle resp.exc=1, exccode 6; data_req_o never asserts; no result.
REQ-032 Word store, addr 0x3000, wdata 0x12345678, gnt delayed 5 cycles -> A-channel fields stable for all 5 cycles; result has rdata 0, err 0.
REQ-033 Load with data_err_i=1 on rvalid -> resp.exc=0; result.err=1.
REQ-034 rst_ni pulsed low during WAIT, then a stray rvalid arrives -> no result_valid; ready=1 after reset.
REQ-035 Back-to-back valid requests -> second request is held off (ready=0) until the cycle after the first result; ids are returned in order.

Source files
------------

// File: rtl/fpu_ss_pkg.sv
// Shared types and constants for the FPU subsystem X-interface memory path.
// Request, response and result bundles plus misalignment exception codes.
package fpu_ss_pkg;

    localparam int unsigned XIdWidth = 4;

    localparam logic [5:0] EXC_LD_ADDR_MISALIGNED = 6'd4;
    localparam logic [5:0] EXC_ST_ADDR_MISALIGNED = 6'd6;

    typedef struct packed {
        logic [XIdWidth-1:0] id;
        logic [31:0]         addr;
        logic [1:0]          mode;
        logic                we;
        logic [2:0]          size;
        logic [3:0]          be;
        logic [1:0]          attr;
        logic [31:0]         wdata;
        logic                last;
        logic                spec;
    } x_mem_req_t;

    typedef struct packed {
        logic       exc;
        logic [5:0] exccode;
        logic       dbg;
    } x_mem_resp_t;

    typedef struct packed {
        logic [XIdWidth-1:0] id;
        logic [31:0]         rdata;
        logic                err;
        logic                dbg;
    } x_mem_result_t;

endpackage

// File: rtl/xif_mem_responder.sv
// Bridges coprocessor X-interface memory requests onto a single OBI data port.
// One transaction in flight; misaligned accesses are rejected at accept time.
module xif_mem_responder
    import fpu_ss_pkg::*;
#(
    parameter logic ZeroWaitAccept = 1'b0
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          x_mem_valid_i,
    output logic          x_mem_ready_o,
    input  x_mem_req_t    x_mem_req_i,
    output x_mem_resp_t   x_mem_resp_o,
    output logic          x_mem_result_valid_o,
    output x_mem_result_t x_mem_result_o,
    output logic          data_req_o,
    input  logic          data_gnt_i,
    output logic [31:0]   data_addr_o,
    output logic          data_we_o,
    output logic [3:0]    data_be_o,
    output logic [31:0]   data_wdata_o,
    input  logic          data_rvalid_i,
    input  logic [31:0]   data_rdata_i,
    input  logic          data_err_i
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        RESULT
    } state_e;

    state_e              state_q, state_d;
    logic [XIdWidth-1:0] id_q, id_d;
    logic [31:0]         addr_q, addr_d;
    logic                we_q, we_d;
    logic [3:0]          be_q, be_d;
    logic [31:0]         wdata_q, wdata_d;
    logic [31:0]         rdata_q, rdata_d;
    logic                err_q, err_d;
    logic                misaligned;
    logic                unused_req;

    assign unused_req = ^{x_mem_req_i.mode, x_mem_req_i.attr,
                          x_mem_req_i.last, x_mem_req_i.spec};

    // Natural alignment of the offered access; sizes above a word never fit
    always_comb begin
        case (x_mem_req_i.size)
            3'd0:    misaligned = 1'b0;
            3'd1:    misaligned = x_mem_req_i.addr[0];
            3'd2:    misaligned = |x_mem_req_i.addr[1:0];
            default: misaligned = 1'b1;
        endcase
    end

    // Next state, latched fields and all handshake outputs
    always_comb begin
        state_d              = state_q;
        id_d                 = id_q;
        addr_d               = addr_q;
        we_d                 = we_q;
        be_d                 = be_q;
        wdata_d              = wdata_q;
        rdata_d              = rdata_q;
        err_d                = err_q;
        x_mem_ready_o        = 1'b0;
        x_mem_resp_o         = '0;
        x_mem_result_valid_o = 1'b0;
        data_req_o           = 1'b0;
        data_addr_o          = addr_q;
        data_we_o            = we_q;
        data_be_o            = be_q;
        data_wdata_o         = wdata_q;
        case (state_q)
            IDLE: begin
                x_mem_ready_o = 1'b1;
                if (x_mem_valid_i) begin
                    if (misaligned) begin
                        x_mem_resp_o.exc     = 1'b1;
                        x_mem_resp_o.exccode = x_mem_req_i.we ?
                            EXC_ST_ADDR_MISALIGNED : EXC_LD_ADDR_MISALIGNED;
                    end else begin
                        id_d    = x_mem_req_i.id;
                        addr_d  = x_mem_req_i.addr;
                        we_d    = x_mem_req_i.we;
                        be_d    = x_mem_req_i.be;
                        wdata_d = x_mem_req_i.wdata;
                        state_d = REQ;
                        if (ZeroWaitAccept) begin
                            data_req_o   = 1'b1;
                            data_addr_o  = x_mem_req_i.addr;
                            data_we_o    = x_mem_req_i.we;
                            data_be_o    = x_mem_req_i.be;
                            data_wdata_o = x_mem_req_i.wdata;
                            if (data_gnt_i) begin
                                state_d = WAIT;
                            end
                        end
                    end
                end
            end
            REQ: begin
                data_req_o = 1'b1;
                if (data_gnt_i) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (data_rvalid_i) begin
                    rdata_d = we_q ? 32'h0 : data_rdata_i;
                    err_d   = data_err_i;
                    state_d = RESULT;
                end
            end
            RESULT: begin
                x_mem_result_valid_o = 1'b1;
                state_d              = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign x_mem_result_o = '{id: id_q, rdata: rdata_q, err: err_q, dbg: 1'b0};

    // State and transaction registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            id_q    <= '0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            be_q    <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_xif_mem_responder.sv
// Self-checking bench for xif_mem_responder (default accept timing).
// Directed scenarios plus randomized transactions against a spec-level model.
module tb_xif_mem_responder;
    import fpu_ss_pkg::*;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          x_mem_valid;
    logic          x_mem_ready;
    x_mem_req_t    req;
    x_mem_resp_t   resp;
    logic          res_valid;
    x_mem_result_t res;
    logic          data_req;
    logic          gnt;
    logic [31:0]   addr;
    logic          we;
    logic [3:0]    be;
    logic [31:0]   wdata;
    logic          rvalid;
    logic [31:0]   rdata;
    logic          err;

    int tests = 0;
    int fails = 0;

    logic          o_ready, o_exc, o_rdbg, o_stable, o_ready_end;
    logic [5:0]    o_code;
    int            o_nreq, o_nres, o_lat;
    x_mem_result_t o_res;
    logic [31:0]   o_addr, o_wdata;
    logic          o_we;
    logic [3:0]    o_be;

    always #5 clk = ~clk;

    xif_mem_responder dut (
        .clk_i                (clk),
        .rst_ni               (rst_n),
        .x_mem_valid_i        (x_mem_valid),
        .x_mem_ready_o        (x_mem_ready),
        .x_mem_req_i          (req),
        .x_mem_resp_o         (resp),
        .x_mem_result_valid_o (res_valid),
        .x_mem_result_o       (res),
        .data_req_o           (data_req),
        .data_gnt_i           (gnt),
        .data_addr_o          (addr),
        .data_we_o            (we),
        .data_be_o            (be),
        .data_wdata_o         (wdata),
        .data_rvalid_i        (rvalid),
        .data_rdata_i         (rdata),
        .data_err_i           (err)
    );

    function automatic bit model_mis(input int sz, input logic [31:0] a);
        if (sz == 0) return 1'b0;
        if (sz == 1) return (a % 2) != 0;
        if (sz == 2) return (a % 4) != 0;
        return 1'b1;
    endfunction

    // Offers one request, plays an OBI slave with the given delays and
    // records what it observed. Starts and ends 1 time unit after posedge.
    task automatic drive_txn(input logic [3:0] id, input logic [31:0] a,
                             input logic w, input logic [2:0] sz,
                             input logic [3:0] b, input logic [31:0] wd,
                             input int gd, input int rd,
                             input logic [31:0] rdat, input logic e);
        int  wcnt;
        bit  granted, done_rv;
        req         = '0;
        req.id      = id;
        req.addr    = a;
        req.we      = w;
        req.size    = sz;
        req.be      = b;
        req.wdata   = wd;
        x_mem_valid = 1'b1;
        @(negedge clk);
        o_ready  = x_mem_ready;
        o_exc    = resp.exc;
        o_code   = resp.exccode;
        o_rdbg   = resp.dbg;
        o_nreq   = 0;
        o_stable = 1'b1;
        o_nres   = 0;
        o_lat    = -1;
        o_res    = '0;
        granted  = 1'b0;
        done_rv  = 1'b0;
        wcnt     = 0;
        @(posedge clk);
        #1;
        x_mem_valid = 1'b0;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            gnt    = 1'b0;
            rvalid = 1'b0;
            if (data_req) begin
                if (o_nreq == 0) begin
                    o_addr  = addr;
                    o_we    = we;
                    o_be    = be;
                    o_wdata = wdata;
                end else if ({addr, we, be, wdata} !==
                             {o_addr, o_we, o_be, o_wdata}) begin
                    o_stable = 1'b0;
                end
                gnt    = (o_nreq == gd);
                o_nreq = o_nreq + 1;
            end else if (granted && !done_rv) begin
                if (wcnt == rd) begin
                    rvalid  = 1'b1;
                    rdata   = rdat;
                    err     = e;
                    done_rv = 1'b1;
                end
                wcnt = wcnt + 1;
            end
            @(negedge clk);
            if (gnt && data_req) granted = 1'b1;
            if (res_valid) begin
                o_nres = o_nres + 1;
                if (o_nres == 1) begin
                    o_lat = cyc;
                    o_res = res;
                end
            end
            @(posedge clk);
            #1;
        end
        gnt         = 1'b0;
        rvalid      = 1'b0;
        o_ready_end = x_mem_ready;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        @(negedge clk);
        tests++;
        if (x_mem_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_ready: got %0b expected 1", x_mem_ready);
        end
        tests++;
        if (data_req !== 1'b0 || res_valid !== 1'b0) begin
            fails++;
            $display("FAIL reset_req_res: got req=%0b res=%0b expected 0 0",
                     data_req, res_valid);
        end
        tests++;
        if (res !== '0) begin
            fails++;
            $display("FAIL reset_result: got %0h expected 0", res);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_word_load();
        drive_txn(4'd3, 32'h1000, 1'b0, 3'd2, 4'hF, 32'h0, 0, 0,
                  32'hDEADBEEF, 1'b0);
        tests++;
        if (o_ready !== 1'b1 || o_exc !== 1'b0 || o_rdbg !== 1'b0) begin
            fails++;
            $display("FAIL load_resp: got rdy=%0b exc=%0b dbg=%0b expected 1 0 0",
                     o_ready, o_exc, o_rdbg);
        end
        tests++;
        if (o_nres !== 1 || o_lat !== 3) begin
            fails++;
            $display("FAIL load_timing: got n=%0d lat=%0d expected 1 3",
                     o_nres, o_lat);
        end
        tests++;
        if (o_res !== '{id: 4'd3, rdata: 32'hDEADBEEF, err: 1'b0, dbg: 1'b0}) begin
            fails++;
            $display("FAIL load_result: got %0h expected id3 deadbeef", o_res);
        end
    endtask

    task automatic test_misaligned_store();
        drive_txn(4'd5, 32'h2001, 1'b1, 3'd1, 4'h3, 32'hCAFE, 0, 0,
                  32'h0, 1'b0);
        tests++;
        if (o_exc !== 1'b1 || o_code !== 6'd6) begin
            fails++;
            $display("FAIL mis_store_exc: got exc=%0b code=%0d expected 1 6",
                     o_exc, o_code);
        end
        tests++;
        if (o_nreq !== 0 || o_nres !== 0 || o_ready_end !== 1'b1) begin
            fails++;
            $display("FAIL mis_store_side: got req=%0d res=%0d rdy=%0b expected 0 0 1",
                     o_nreq, o_nres, o_ready_end);
        end
    endtask

    task automatic test_delayed_store();
        drive_txn(4'd7, 32'h3000, 1'b1, 3'd2, 4'hF, 32'h12345678, 5, 0,
                  32'hA5A5A5A5, 1'b0);
        tests++;
        if (o_nreq !== 6 || o_stable !== 1'b1) begin
            fails++;
            $display("FAIL store_hold: got cycles=%0d stable=%0b expected 6 1",
                     o_nreq, o_stable);
        end
        tests++;
        if ({o_addr, o_we, o_be, o_wdata} !==
            {32'h3000, 1'b1, 4'hF, 32'h12345678}) begin
            fails++;
            $display("FAIL store_achan: got %0h %0b %0h %0h expected 3000 1 f 12345678",
                     o_addr, o_we, o_be, o_wdata);
        end
        tests++;
        if (o_nres !== 1 || o_lat !== 8 || o_res.rdata !== 32'h0 ||
            o_res.err !== 1'b0 || o_res.id !== 4'd7) begin
            fails++;
            $display("FAIL store_result: got n=%0d lat=%0d %0h expected 1 8 id7 rdata0",
                     o_nres, o_lat, o_res);
        end
    endtask

    task automatic test_bus_error();
        drive_txn(4'd9, 32'h4004, 1'b0, 3'd2, 4'hF, 32'h0, 1, 2,
                  32'h11112222, 1'b1);
        tests++;
        if (o_exc !== 1'b0) begin
            fails++;
            $display("FAIL buserr_exc: got %0b expected 0", o_exc);
        end
        tests++;
        if (o_nres !== 1 || o_res.err !== 1'b1 || o_res.dbg !== 1'b0) begin
            fails++;
            $display("FAIL buserr_result: got n=%0d err=%0b dbg=%0b expected 1 1 0",
                     o_nres, o_res.err, o_res.dbg);
        end
    endtask

    task automatic test_reset_in_wait();
        int nres;
        req         = '0;
        req.id      = 4'd2;
        req.addr    = 32'h5000;
        req.size    = 3'd2;
        req.be      = 4'hF;
        x_mem_valid = 1'b1;
        @(posedge clk);
        #1;
        x_mem_valid = 1'b0;
        gnt         = 1'b1;
        @(posedge clk);
        #1;
        gnt = 1'b0;
        @(negedge clk);
        tests++;
        if (x_mem_ready !== 1'b0 || data_req !== 1'b0) begin
            fails++;
            $display("FAIL rst_wait_busy: got rdy=%0b req=%0b expected 0 0",
                     x_mem_ready, data_req);
        end
        rst_n = 1'b0;
        #1;
        tests++;
        if (x_mem_ready !== 1'b1) begin
            fails++;
            $display("FAIL rst_wait_ready: got %0b expected 1", x_mem_ready);
        end
        @(posedge clk);
        #1;
        rst_n  = 1'b1;
        rvalid = 1'b1;
        rdata  = 32'hBADBAD00;
        err    = 1'b0;
        nres   = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (res_valid) nres++;
            @(posedge clk);
            #1;
            rvalid = 1'b0;
        end
        tests++;
        if (nres !== 0 || x_mem_ready !== 1'b1) begin
            fails++;
            $display("FAIL rst_wait_stray: got res=%0d rdy=%0b expected 0 1",
                     nres, x_mem_ready);
        end
    endtask

    task automatic test_back_to_back();
        int         acc[$];
        int         rescyc[$];
        logic [3:0] ids[$];
        bit         pend;
        int         stage;
        req         = '0;
        req.id      = 4'hA;
        req.addr    = {$urandom} & 32'hFFFF_FFFC;
        req.size    = 3'd2;
        req.be      = 4'hF;
        x_mem_valid = 1'b1;
        pend        = 1'b0;
        stage       = 0;
        for (int c = 0; c < 30; c++) begin
            gnt    = data_req;
            rvalid = pend;
            rdata  = $urandom;
            err    = 1'b0;
            pend   = 1'b0;
            @(negedge clk);
            if (data_req && gnt) pend = 1'b1;
            if (x_mem_valid && x_mem_ready) acc.push_back(c);
            if (res_valid) begin
                rescyc.push_back(c);
                ids.push_back(res.id);
            end
            @(posedge clk);
            #1;
            if (acc.size() == 1 && stage == 0) begin
                stage    = 1;
                req.id   = 4'h5;
                req.addr = {$urandom} & 32'hFFFF_FFFC;
            end else if (acc.size() == 2 && stage == 1) begin
                stage       = 2;
                x_mem_valid = 1'b0;
            end
        end
        gnt    = 1'b0;
        rvalid = 1'b0;
        tests++;
        if (acc.size() != 2 || rescyc.size() != 2) begin
            fails++;
            $display("FAIL b2b_counts: got acc=%0d res=%0d expected 2 2",
                     acc.size(), rescyc.size());
        end
        tests++;
        if (((acc.size() > 1) ? acc[1] : -1) !==
            ((rescyc.size() > 0) ? rescyc[0] + 1 : -2)) begin
            fails++;
            $display("FAIL b2b_holdoff: got second accept %0d expected %0d",
                     (acc.size() > 1) ? acc[1] : -1,
                     (rescyc.size() > 0) ? rescyc[0] + 1 : -2);
        end
        tests++;
        if (ids.size() != 2 || ids[0] !== 4'hA || ids[1] !== 4'h5) begin
            fails++;
            $display("FAIL b2b_order: got %p expected a 5", ids);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 30; n++) begin
            logic [3:0]  id;
            logic [31:0] a, wd, rdat;
            logic        w, e, mis;
            int          sz, gd, rd;
            id   = 4'($urandom);
            a    = $urandom;
            wd   = $urandom;
            rdat = $urandom;
            w    = 1'($urandom);
            e    = 1'($urandom);
            sz   = $urandom_range(0, 4);
            gd   = $urandom_range(0, 4);
            rd   = $urandom_range(0, 4);
            if ($urandom_range(0, 1) == 1) a = a & ~32'h3;
            mis = model_mis(sz, a);
            drive_txn(id, a, w, 3'(sz), 4'($urandom), wd, gd, rd, rdat, e);
            tests++;
            if (o_exc !== mis) begin
                fails++;
                $display("FAIL rnd_exc[%0d]: got %0b expected %0b (sz=%0d a=%0h)",
                         n, o_exc, mis, sz, a);
            end
            if (mis) begin
                tests++;
                if (o_code !== (w ? 6'd6 : 6'd4) || o_nreq !== 0 || o_nres !== 0) begin
                    fails++;
                    $display("FAIL rnd_mis[%0d]: got code=%0d req=%0d res=%0d expected %0d 0 0",
                             n, o_code, o_nreq, o_nres, w ? 6 : 4);
                end
            end else begin
                tests++;
                if (o_nres !== 1 || o_lat !== 3 + gd + rd) begin
                    fails++;
                    $display("FAIL rnd_lat[%0d]: got n=%0d lat=%0d expected 1 %0d",
                             n, o_nres, o_lat, 3 + gd + rd);
                end
                tests++;
                if (o_res.id !== id || o_res.rdata !== (w ? 32'h0 : rdat) ||
                    o_res.err !== e || o_code !== 6'd0) begin
                    fails++;
                    $display("FAIL rnd_res[%0d]: got %0h code=%0d expected id=%0h rdata=%0h err=%0b",
                             n, o_res, o_code, id, w ? 32'h0 : rdat, e);
                end
                tests++;
                if (o_stable !== 1'b1 || o_addr !== a || o_we !== w ||
                    o_wdata !== wd) begin
                    fails++;
                    $display("FAIL rnd_achan[%0d]: got %0h %0b %0h stable=%0b expected %0h %0b %0h",
                             n, o_addr, o_we, o_wdata, o_stable, a, w, wd);
                end
            end
        end
    endtask

    initial begin
        x_mem_valid = 1'b0;
        req         = '0;
        gnt         = 1'b0;
        rvalid      = 1'b0;
        rdata       = '0;
        err         = 1'b0;
        rst_n       = 1'b0;
        #1;
        test_reset();
        test_word_load();
        test_misaligned_store();
        test_delayed_store();
        test_bus_error();
        test_reset_in_wait();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
